// File: rtl/sel_sort_ctrl_pkg.sv
// Shared types and helpers for the selection-sort controller.
//   state_e      : controller states
//   SORT_*       : default geometry (entries, address width, data width)
//   better()     : strict ordering test used by the scan loop
package sel_sort_ctrl_pkg;

    localparam int SORT_N     = 8;
    localparam int SORT_AW    = 3;
    localparam int SORT_DW    = 8;
    // Comparison width; operands are zero-extended, so unsigned order is kept.
    localparam int SORT_CMP_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_I  = 3'd1,
        LD_I  = 3'd2,
        SCAN  = 3'd3,
        SWAP1 = 3'd4,
        SWAP2 = 3'd5,
        NEXT  = 3'd6,
        DONE  = 3'd7
    } state_e;

    // True when a must replace b as the current extreme. Strict, so equal
    // values never displace the first occurrence.
    function automatic logic better(input logic [SORT_CMP_W-1:0] a,
                                    input logic [SORT_CMP_W-1:0] b,
                                    input logic                  descend);
        logic res;
        if (descend) begin
            res = (a > b);
        end else begin
            res = (a < b);
        end
        return res;
    endfunction

endpackage

// File: rtl/sel_sort_ctrl_port_mux.sv
// RAM port steering: the host owns the port between sorts, the sequencer
// owns it while a sort runs.
//   host_sel             : 1 = host drive, 0 = sequencer drive
//   init_mode/addr/data  : host write enable, address, data
//   fsm_we/addr/wdata    : sequencer write enable, address, data
//   ram_we/addr/wdata    : drive to the external RAM
module sel_sort_ctrl_port_mux
    import sel_sort_ctrl_pkg::*;
#(
    parameter int AW = SORT_AW,
    parameter int DW = SORT_DW
) (
    input  logic          host_sel,
    input  logic          init_mode,
    input  logic [AW-1:0] init_addr,
    input  logic [DW-1:0] init_data,
    input  logic          fsm_we,
    input  logic [AW-1:0] fsm_addr,
    input  logic [DW-1:0] fsm_wdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata
);

    // Select the port owner.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = {AW{1'b0}};
        ram_wdata = {DW{1'b0}};
        if (host_sel) begin
            ram_we    = init_mode;
            ram_addr  = init_addr;
            ram_wdata = init_data;
        end else begin
            ram_we    = fsm_we;
            ram_addr  = fsm_addr;
            ram_wdata = fsm_wdata;
        end
    end

endmodule

// File: rtl/sel_sort_ctrl.sv
// In-place selection-sort sequencer for a single-port RAM with one-cycle
// read latency.
//   clk, reset      : rising-edge clock, asynchronous active-low reset
//   s               : start request (accepted in IDLE/DONE with init_mode=0)
//   init_mode/addr/data : host load/readback port, used while not busy
//   host_rdata      : RAM read data returned to the host
//   busy, done      : sort in progress / sort finished (held until next start)
//   ram_addr/we/wdata/rdata : external RAM port
// The sequencer drive of the RAM port is computed one cycle ahead and
// registered, so the port value seen in each state is a flop output.
module sel_sort_ctrl
    import sel_sort_ctrl_pkg::*;
#(
    parameter int N       = SORT_N,
    parameter int AW      = SORT_AW,
    parameter int DW      = SORT_DW,
    parameter int DESCEND = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic          init_mode,
    input  logic [AW-1:0] init_addr,
    input  logic [DW-1:0] init_data,
    output logic [DW-1:0] host_rdata,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [AW-1:0] LAST_J  = AW'(N - 1);
    localparam logic [AW-1:0] LAST_I  = AW'(N - 2);
    localparam logic [AW-1:0] ONE_A   = AW'(1);
    localparam logic [AW-1:0] TWO_A   = AW'(2);
    localparam logic          DESC_B  = (DESCEND != 0);

    state_e        state_r, state_n;
    logic [AW-1:0] i_r, i_n;
    logic [AW-1:0] j_r, j_n;
    logic [AW-1:0] midx_r, midx_n;
    logic [DW-1:0] ai_r, ai_n;
    logic [DW-1:0] min_r, min_n;
    logic          busy_r, busy_n;
    logic          done_r, done_n;
    logic          host_sel_r, host_sel_n;
    logic          fsm_we_r, fsm_we_n;
    logic [AW-1:0] fsm_addr_r, fsm_addr_n;
    logic [DW-1:0] fsm_wdata_r, fsm_wdata_n;

    logic          upd_s;
    logic [DW-1:0] min_scan_s;
    logic [AW-1:0] midx_scan_s;
    logic          start_s;

    assign start_s = s & ~init_mode;

    // Scan-step candidate: the incoming word replaces the running extreme.
    always_comb begin
        upd_s       = better(SORT_CMP_W'(ram_rdata), SORT_CMP_W'(min_r), DESC_B);
        min_scan_s  = min_r;
        midx_scan_s = midx_r;
        if (upd_s) begin
            min_scan_s  = ram_rdata;
            midx_scan_s = j_r;
        end else begin
            min_scan_s  = min_r;
            midx_scan_s = midx_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start_s) state_n = RD_I;
                else         state_n = state_r;
            end
            RD_I:  state_n = LD_I;
            LD_I:  state_n = SCAN;
            SCAN: begin
                if (j_r == LAST_J) state_n = SWAP1;
                else               state_n = SCAN;
            end
            SWAP1: begin
                if (midx_r != i_r) state_n = SWAP2;
                else               state_n = NEXT;
            end
            SWAP2: state_n = NEXT;
            NEXT: begin
                if (i_r == LAST_I) state_n = DONE;
                else               state_n = RD_I;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath and output next values; the port drive is the value the
    // following state must present.
    always_comb begin
        i_n         = i_r;
        j_n         = j_r;
        midx_n      = midx_r;
        ai_n        = ai_r;
        min_n       = min_r;
        busy_n      = busy_r;
        done_n      = done_r;
        host_sel_n  = host_sel_r;
        fsm_we_n    = 1'b0;
        fsm_addr_n  = {AW{1'b0}};
        fsm_wdata_n = {DW{1'b0}};
        case (state_r)
            IDLE, DONE: begin
                if (start_s) begin
                    i_n        = {AW{1'b0}};
                    done_n     = 1'b0;
                    busy_n     = 1'b1;
                    host_sel_n = 1'b0;
                    fsm_addr_n = {AW{1'b0}};
                end else begin
                    host_sel_n = 1'b1;
                end
            end
            RD_I: begin
                fsm_addr_n = i_r + ONE_A;
            end
            LD_I: begin
                ai_n       = ram_rdata;
                min_n      = ram_rdata;
                midx_n     = i_r;
                j_n        = i_r + ONE_A;
                // Prefetch A[j+1] so each SCAN cycle sees one new word.
                fsm_addr_n = i_r + TWO_A;
            end
            SCAN: begin
                min_n  = min_scan_s;
                midx_n = midx_scan_s;
                if (j_r == LAST_J) begin
                    fsm_addr_n  = i_r;
                    fsm_we_n    = (midx_scan_s != i_r);
                    fsm_wdata_n = min_scan_s;
                end else begin
                    j_n        = j_r + ONE_A;
                    fsm_addr_n = j_r + TWO_A;
                end
            end
            SWAP1: begin
                if (midx_r != i_r) begin
                    fsm_addr_n  = midx_r;
                    fsm_we_n    = 1'b1;
                    fsm_wdata_n = ai_r;
                end else begin
                    fsm_we_n    = 1'b0;
                end
            end
            SWAP2: begin
                fsm_we_n = 1'b0;
            end
            NEXT: begin
                if (i_r == LAST_I) begin
                    busy_n     = 1'b0;
                    done_n     = 1'b1;
                    host_sel_n = 1'b1;
                end else begin
                    i_n        = i_r + ONE_A;
                    fsm_addr_n = i_r + ONE_A;
                end
            end
            default: begin
                busy_n     = 1'b0;
                host_sel_n = 1'b1;
            end
        endcase
    end

    // Datapath and registered output drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_r         <= {AW{1'b0}};
            j_r         <= {AW{1'b0}};
            midx_r      <= {AW{1'b0}};
            ai_r        <= {DW{1'b0}};
            min_r       <= {DW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            host_sel_r  <= 1'b1;
            fsm_we_r    <= 1'b0;
            fsm_addr_r  <= {AW{1'b0}};
            fsm_wdata_r <= {DW{1'b0}};
        end else begin
            i_r         <= i_n;
            j_r         <= j_n;
            midx_r      <= midx_n;
            ai_r        <= ai_n;
            min_r       <= min_n;
            busy_r      <= busy_n;
            done_r      <= done_n;
            host_sel_r  <= host_sel_n;
            fsm_we_r    <= fsm_we_n;
            fsm_addr_r  <= fsm_addr_n;
            fsm_wdata_r <= fsm_wdata_n;
        end
    end

    sel_sort_ctrl_port_mux #(
        .AW (AW),
        .DW (DW)
    ) u_port_mux (
        .host_sel  (host_sel_r),
        .init_mode (init_mode),
        .init_addr (init_addr),
        .init_data (init_data),
        .fsm_we    (fsm_we_r),
        .fsm_addr  (fsm_addr_r),
        .fsm_wdata (fsm_wdata_r),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata)
    );

    assign host_rdata = ram_rdata;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_sel_sort_ctrl.sv
module tb_sel_sort_ctrl;

    logic       clk = 1'b0;
    logic       reset;

    // Ascending instance
    logic       s_a, mode_a;
    logic [2:0] iaddr_a;
    logic [7:0] idata_a, hrd_a, wd_a, rd_a;
    logic       busy_a, done_a, we_a;
    logic [2:0] addr_a;
    logic [7:0] mem_a [8];

    // Descending instance
    logic       s_d, mode_d;
    logic [2:0] iaddr_d;
    logic [7:0] idata_d, hrd_d, wd_d, rd_d;
    logic       busy_d, done_d, we_d;
    logic [2:0] addr_d;
    logic [7:0] mem_d [8];

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] vec [8];
    logic [7:0] exp_v [8];
    logic [7:0] got [8];
    int cyc, wes;

    always #5 clk = ~clk;

    sel_sort_ctrl #(.N(8), .AW(3), .DW(8), .DESCEND(0)) dut_a (
        .clk(clk), .reset(reset), .s(s_a), .init_mode(mode_a),
        .init_addr(iaddr_a), .init_data(idata_a), .host_rdata(hrd_a),
        .busy(busy_a), .done(done_a), .ram_addr(addr_a), .ram_we(we_a),
        .ram_wdata(wd_a), .ram_rdata(rd_a)
    );

    sel_sort_ctrl #(.N(8), .AW(3), .DW(8), .DESCEND(1)) dut_d (
        .clk(clk), .reset(reset), .s(s_d), .init_mode(mode_d),
        .init_addr(iaddr_d), .init_data(idata_d), .host_rdata(hrd_d),
        .busy(busy_d), .done(done_d), .ram_addr(addr_d), .ram_we(we_d),
        .ram_wdata(wd_d), .ram_rdata(rd_d)
    );

    // Synchronous single-port RAM models, one-cycle read latency
    always @(posedge clk) begin
        if (we_a) mem_a[addr_a] <= wd_a;
        rd_a <= mem_a[addr_a];
        if (we_d) mem_d[addr_d] <= wd_d;
        rd_d <= mem_d[addr_d];
    end

    task automatic load(input int sel, input logic [7:0] v [8]);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (sel == 1) begin
                mode_d = 1'b1; iaddr_d = 3'(k); idata_d = v[k];
            end else begin
                mode_a = 1'b1; iaddr_a = 3'(k); idata_a = v[k];
            end
        end
        @(negedge clk);
        mode_a = 1'b0; mode_d = 1'b0; iaddr_a = 3'd0; iaddr_d = 3'd0;
    endtask

    task automatic read_back(input int sel, output logic [7:0] r [8]);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (sel == 1) iaddr_d = 3'(k);
            else          iaddr_a = 3'(k);
            @(negedge clk);
            r[k] = (sel == 1) ? hrd_d : hrd_a;
        end
    endtask

    // Start a sort and count busy cycles and write pulses; poke=1 drives host
    // write and start requests during part of the sort.
    task automatic run_sort(input int sel, input int poke, output int c, output int w);
        logic b, d;
        c = 0; w = 0;
        @(negedge clk);
        if (sel == 1) s_d = 1'b1; else s_a = 1'b1;
        @(negedge clk);
        s_a = 1'b0; s_d = 1'b0;
        b = (sel == 1) ? busy_d : busy_a;
        d = (sel == 1) ? done_d : done_a;
        n_chk++;
        if (b !== 1'b1 || d !== 1'b0) begin
            n_fail++;
            $display("FAIL start_accept: busy=%b done=%b, required busy=1 done=0", b, d);
        end
        while (((sel == 1) ? busy_d : busy_a) && c < 500) begin
            if ((sel == 1) ? we_d : we_a) w++;
            c++;
            if (poke != 0 && c >= 5 && c < 15) begin
                mode_a = 1'b1; iaddr_a = 3'd2; idata_a = 8'd99; s_a = 1'b1;
            end else begin
                mode_a = 1'b0; iaddr_a = 3'd0; idata_a = 8'd0; s_a = 1'b0;
            end
            @(negedge clk);
        end
        mode_a = 1'b0; s_a = 1'b0; idata_a = 8'd0;
        n_chk++;
        if (c >= 500) begin
            n_fail++;
            $display("FAIL sort_timeout: busy still high after %0d cycles, required to drop", c);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        s_a = 1'b0; mode_a = 1'b0; iaddr_a = 3'd0; idata_a = 8'd0;
        s_d = 1'b0; mode_d = 1'b0; iaddr_d = 3'd0; idata_d = 8'd0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || we_a !== 1'b0 ||
            addr_a !== 3'd0 || wd_a !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b we=%b addr=%0d wdata=%0d, required all 0",
                     busy_a, done_a, we_a, addr_a, wd_a);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        vec   = '{8'd90, 8'd25, 8'd60, 8'd15, 8'd30, 8'd75, 8'd45, 8'd10};
        exp_v = '{8'd10, 8'd15, 8'd25, 8'd30, 8'd45, 8'd60, 8'd75, 8'd90};
        load(0, vec);
        run_sort(0, 0, cyc, wes);
        n_chk++;
        if (done_a !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_flags: done=%b busy=%b, required done=1 busy=0", done_a, busy_a);
        end
        read_back(0, got);
        for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (got[k] !== exp_v[k]) begin
                n_fail++;
                $display("FAIL basic_data[%0d]: got %0d, required %0d", k, got[k], exp_v[k]);
            end
        end
        repeat (5) @(negedge clk);
        n_chk++;
        if (done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL done_hold: done=%b, required 1", done_a);
        end
    endtask

    task automatic test_presorted();
        vec = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load(0, vec);
        run_sort(0, 0, cyc, wes);
        n_chk++;
        if (wes != 0) begin
            n_fail++;
            $display("FAIL presorted_writes: got %0d, required 0", wes);
        end
        n_chk++;
        if (cyc != 56) begin
            n_fail++;
            $display("FAIL presorted_cycles: got %0d, required 56", cyc);
        end
    endtask

    task automatic test_reverse();
        vec   = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        exp_v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load(0, vec);
        run_sort(0, 0, cyc, wes);
        n_chk++;
        if (wes != 8) begin
            n_fail++;
            $display("FAIL reverse_writes: got %0d, required 8", wes);
        end
        n_chk++;
        if (cyc != 60) begin
            n_fail++;
            $display("FAIL reverse_cycles: got %0d, required 60", cyc);
        end
        read_back(0, got);
        for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (got[k] !== exp_v[k]) begin
                n_fail++;
                $display("FAIL reverse_data[%0d]: got %0d, required %0d", k, got[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_duplicates();
        vec   = '{8'd5, 8'd3, 8'd5, 8'd3, 8'd5, 8'd3, 8'd5, 8'd3};
        exp_v = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd5, 8'd5, 8'd5, 8'd5};
        load(0, vec);
        run_sort(0, 0, cyc, wes);
        read_back(0, got);
        for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (got[k] !== exp_v[k]) begin
                n_fail++;
                $display("FAIL dup_data[%0d]: got %0d, required %0d", k, got[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_descend();
        vec   = '{8'd90, 8'd25, 8'd60, 8'd15, 8'd30, 8'd75, 8'd45, 8'd10};
        exp_v = '{8'd90, 8'd75, 8'd60, 8'd45, 8'd30, 8'd25, 8'd15, 8'd10};
        load(1, vec);
        run_sort(1, 0, cyc, wes);
        read_back(1, got);
        for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (got[k] !== exp_v[k]) begin
                n_fail++;
                $display("FAIL descend_data[%0d]: got %0d, required %0d", k, got[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_busy_ignored();
        vec   = '{8'd90, 8'd25, 8'd60, 8'd15, 8'd30, 8'd75, 8'd45, 8'd10};
        exp_v = '{8'd10, 8'd15, 8'd25, 8'd30, 8'd45, 8'd60, 8'd75, 8'd90};
        load(0, vec);
        run_sort(0, 1, cyc, wes);
        read_back(0, got);
        for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (got[k] !== exp_v[k]) begin
                n_fail++;
                $display("FAIL busy_ignore_data[%0d]: got %0d, required %0d", k, got[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec   = '{8'd90, 8'd25, 8'd60, 8'd15, 8'd30, 8'd75, 8'd45, 8'd10};
        exp_v = '{8'd10, 8'd15, 8'd25, 8'd30, 8'd45, 8'd60, 8'd75, 8'd90};
        load(0, vec);
        @(negedge clk);
        s_a = 1'b1;
        @(negedge clk);
        s_a = 1'b0;
        repeat (4) @(negedge clk);  // inside the first scan
        reset = 1'b0;
        #1;
        n_chk++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || we_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b we=%b, required all 0", busy_a, done_a, we_a);
        end
        @(negedge clk);
        reset = 1'b1;
        load(0, vec);
        run_sort(0, 0, cyc, wes);
        read_back(0, got);
        for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (got[k] !== exp_v[k]) begin
                n_fail++;
                $display("FAIL reset_reload_data[%0d]: got %0d, required %0d", k, got[k], exp_v[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_presorted();
        test_reverse();
        test_duplicates();
        test_descend();
        test_busy_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
